regfile64_wb_ctrl: RTL and testbench



---
 rtl/regfile64_pkg.sv | 18 +
 rtl/regfile64_wb_ctrl_wb_buf.sv | 48 ++++
 rtl/regfile64_wb_ctrl.sv | 140 ++++++++++++++
 tb/tb_regfile64_wb_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile64_pkg.sv
// Shared types and defaults for the regfile64 write-side controller.
// Widths match the attached 64-bit, 32-entry register file.
package regfile64_pkg;

  localparam int RF_DATA_W = 64;
  localparam int RF_ADDR_W = 5;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } st_e;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/regfile64_wb_ctrl_wb_buf.sv
// One-entry result buffer for a single producer: holds addr/data, tracks
// whether it has been passed over while its peer loaded (age).
module wb_buf
  import regfile64_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              gnt,
  input  logic              peer_load,
  output logic              load,
  output logic              full,
  output logic              age,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  assign in_ready = en && (!full || gnt);
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= 1'b0;
      age  <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      age  <= 1'b0;
      addr <= in_addr;
      data <= in_data;
    end else if (gnt) begin
      full <= 1'b0;
      age  <= 1'b0;
    end else if (full && peer_load) begin
      // passed over while the peer took a newer result
      age  <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile64_wb_ctrl.sv
// Write-port controller for regfile64: zero sweep after reset, then
// arbitrates buffered ALU and load results onto one write per cycle.
module regfile64_wb_ctrl
  import regfile64_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              W_En,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] WR,
  output logic              init_done
);

  st_e state_q, state_n;
  src_e ptr_q, ptr_n;
  logic [ADDR_W:0] cnt_q, cnt_n;

  logic              w_en_n;
  logic [ADDR_W-1:0] w_addr_n;
  logic [DATA_W-1:0] wr_n;
  logic              done_n;

  logic              run;
  logic              a_full, a_age, a_gnt, a_load;
  logic              m_full, m_age, m_gnt, m_load;
  logic [ADDR_W-1:0] a_addr, m_addr, sel_addr;
  logic [DATA_W-1:0] a_data, m_data, sel_data;
  logic              zero_hit;

  assign run = (state_q == ST_RUN);

  wb_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu (
    .clk(clk), .reset_n(reset_n), .en(run),
    .in_valid(alu_valid), .in_ready(alu_ready),
    .in_addr(alu_addr), .in_data(alu_data),
    .gnt(a_gnt), .peer_load(m_load), .load(a_load),
    .full(a_full), .age(a_age),
    .addr(a_addr), .data(a_data)
  );

  wb_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk), .reset_n(reset_n), .en(run),
    .in_valid(mem_valid), .in_ready(mem_ready),
    .in_addr(mem_addr), .in_data(mem_data),
    .gnt(m_gnt), .peer_load(a_load), .load(m_load),
    .full(m_full), .age(m_age),
    .addr(m_addr), .data(m_data)
  );

  always_comb begin
    a_gnt = 1'b0;
    m_gnt = 1'b0;
    if (run) begin
      unique case (1'b1)
        a_full && !m_full: a_gnt = 1'b1;
        m_full && !a_full: m_gnt = 1'b1;
        a_full && m_full && (a_age != m_age): begin
          a_gnt = a_age;
          m_gnt = m_age;
        end
        a_full && m_full && (a_age == m_age): begin
          a_gnt = (ptr_q == SRC_ALU);
          m_gnt = (ptr_q == SRC_MEM);
        end
        default: ;
      endcase
    end
  end

  assign sel_addr = m_gnt ? m_addr : a_addr;
  assign sel_data = m_gnt ? m_data : a_data;
  assign zero_hit = (ZERO_R0 != 0) && (sel_addr == '0);

  always_comb begin
    state_n  = state_q;
    ptr_n    = ptr_q;
    cnt_n    = cnt_q;
    w_en_n   = 1'b0;
    w_addr_n = W_Addr;
    wr_n     = WR;
    done_n   = init_done;
    unique case (state_q)
      ST_INIT: begin
        if (cnt_q[ADDR_W]) begin
          state_n = ST_RUN;
          done_n  = 1'b1;
        end else begin
          w_en_n   = 1'b1;
          w_addr_n = cnt_q[ADDR_W-1:0];
          wr_n     = '0;
          cnt_n    = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if ((a_gnt || m_gnt) && !zero_hit) begin
          w_en_n   = 1'b1;
          w_addr_n = sel_addr;
          wr_n     = sel_data;
        end
        if (a_full && m_full) begin
          ptr_n = (ptr_q == SRC_ALU) ? SRC_MEM : SRC_ALU;
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_INIT;
      ptr_q     <= SRC_ALU;
      cnt_q     <= '0;
      W_En      <= 1'b0;
      W_Addr    <= '0;
      WR        <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_n;
      ptr_q     <= ptr_n;
      cnt_q     <= cnt_n;
      W_En      <= w_en_n;
      W_Addr    <= w_addr_n;
      WR        <= wr_n;
      init_done <= done_n;
    end
  end

endmodule

// File: tb/tb_regfile64_wb_ctrl.sv
// Bench for regfile64_wb_ctrl: directed vector table, reset corner cases
// and random traffic against a timestamp-ordered reference model.
module tb_regfile64_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_addr, mem_addr;
  logic [63:0] alu_data, mem_data;
  logic        W_En;
  logic [4:0]  W_Addr;
  logic [63:0] WR;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  regfile64_wb_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .W_En(W_En), .W_Addr(W_Addr), .WR(WR),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  // attached register file (no reset, like regfile64)
  logic [63:0] rf [32];
  always @(posedge clk) if (W_En) rf[W_Addr] <= WR;

  // reference model state
  bit          m_run, m_done;
  int          m_sweep, rr, tick;
  bit          pv [2];
  logic [4:0]  pa [2];
  logic [63:0] pd [2];
  int          ps [2];
  bit          e_wen;
  logic [4:0]  e_addr;
  logic [63:0] e_wr;
  logic [63:0] erf [32];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at tick %0d: got %h want %h", nm, tick, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_sweep = 0; rr = 0;
    pv[0] = 0; pv[1] = 0;
  endtask

  task automatic drive(input bit av, input logic [4:0] aa,
                       input logic [63:0] ad, input bit mv,
                       input logic [4:0] ma, input logic [63:0] md);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
  endtask

  // one clock: predict, check readies, take the edge, check outputs
  task automatic step();
    int g;
    bit ra, rm;
    g = -1;
    if (m_run) begin
      if (pv[0] && pv[1])
        g = (ps[0] < ps[1]) ? 0 : (ps[1] < ps[0]) ? 1 : rr;
      else if (pv[0]) g = 0;
      else if (pv[1]) g = 1;
    end
    ra = m_run && (!pv[0] || g == 0);
    rm = m_run && (!pv[1] || g == 1);
    chk("alu_ready", 64'(alu_ready), 64'(ra));
    chk("mem_ready", 64'(mem_ready), 64'(rm));
    e_wen = 0;
    if (!m_run) begin
      if (m_sweep < 32) begin
        e_wen = 1; e_addr = m_sweep[4:0]; e_wr = '0;
        m_sweep++;
      end else begin
        m_run = 1; m_done = 1;
      end
    end else if (g >= 0) begin
      if (pa[g] != 5'd0) begin
        e_wen = 1; e_addr = pa[g]; e_wr = pd[g];
      end
      if (pv[0] && pv[1]) rr ^= 1;
      pv[g] = 0;
    end
    if (ra && alu_valid) begin
      pv[0] = 1; pa[0] = alu_addr; pd[0] = alu_data; ps[0] = tick;
    end
    if (rm && mem_valid) begin
      pv[1] = 1; pa[1] = mem_addr; pd[1] = mem_data; ps[1] = tick;
    end
    if (e_wen) erf[e_addr] = e_wr;
    tick++;
    @(posedge clk);
    #1;
    chk("W_En", 64'(W_En), 64'(e_wen));
    chk("init_done", 64'(init_done), 64'(m_done));
    if (e_wen) begin
      chk("W_Addr", 64'(W_Addr), 64'(e_addr));
      chk("WR", WR, e_wr);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".W_En"}, 64'(W_En), 64'd0);
    chk({nm, ".W_Addr"}, 64'(W_Addr), 64'd0);
    chk({nm, ".WR"}, WR, 64'd0);
    chk({nm, ".init_done"}, 64'(init_done), 64'd0);
    chk({nm, ".alu_ready"}, 64'(alu_ready), 64'd0);
    chk({nm, ".mem_ready"}, 64'(mem_ready), 64'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          av;
    logic [4:0]  aa;
    logic [63:0] ad;
    bit          mv;
    logic [4:0]  ma;
    logic [63:0] md;
    bit          ra;
    bit          rm;
    bit          wen;
    logic [4:0]  wa;
    logic [63:0] wd;
  } vec_t;

  function automatic vec_t mk(input bit av, input int aa, input logic [63:0] ad,
                              input bit mv, input int ma, input logic [63:0] md,
                              input bit ra, input bit rm, input bit wen,
                              input int wa, input logic [63:0] wd);
    vec_t v;
    v.av = av; v.aa = 5'(aa); v.ad = ad;
    v.mv = mv; v.ma = 5'(ma); v.md = md;
    v.ra = ra; v.rm = rm; v.wen = wen; v.wa = 5'(wa); v.wd = wd;
    return v;
  endfunction

  vec_t tbl [22];

  initial begin
    tbl[0]  = mk(1, 5, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 5, 64'hDEAD_BEEF_0000_0001);
    tbl[2]  = mk(1, 7, 64'h70, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[3]  = mk(1, 8, 64'h80, 0, 0, 0, 1, 1, 1, 7, 64'h70);
    tbl[4]  = mk(1, 9, 64'h90, 0, 0, 0, 1, 1, 1, 8, 64'h80);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 9, 64'h90);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[7]  = mk(1, 3, 64'h11, 1, 3, 64'h22, 1, 1, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 64'h11);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 64'h22);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[11] = mk(1, 10, 64'hA0, 1, 11, 64'hB0, 1, 1, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 11, 64'hB0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 10, 64'hA0);
    tbl[14] = mk(1, 12, 64'hC0, 1, 13, 64'hD0, 1, 1, 0, 0, 0);
    tbl[15] = mk(1, 14, 64'hE0, 0, 0, 0, 1, 0, 1, 12, 64'hC0);
    tbl[16] = mk(1, 15, 64'hF0, 0, 0, 0, 0, 1, 1, 13, 64'hD0);
    tbl[17] = mk(1, 15, 64'hF0, 0, 0, 0, 1, 1, 1, 14, 64'hE0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 15, 64'hF0);
    tbl[19] = mk(1, 0, 64'hFF, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);

    tick = 0;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #23;
    chk_reset_vals("por");

    // sweep interrupted after address 12
    release_reset();
    for (int i = 0; i < 13; i++) step();
    chk("mid.addr12", 64'(W_Addr), 64'd12);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("mid_sweep_rst");

    // full sweep from address 0
    release_reset();
    for (int i = 0; i < 33; i++) step();
    for (int i = 0; i < 32; i++) chk("init_rf", rf[i], 64'd0);
    step();
    step();

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md);
      chk($sformatf("vec%0d.alu_ready", i), 64'(alu_ready), 64'(tbl[i].ra));
      chk($sformatf("vec%0d.mem_ready", i), 64'(mem_ready), 64'(tbl[i].rm));
      step();
      chk($sformatf("vec%0d.W_En", i), 64'(W_En), 64'(tbl[i].wen));
      if (tbl[i].wen) begin
        chk($sformatf("vec%0d.W_Addr", i), 64'(W_Addr), 64'(tbl[i].wa));
        chk($sformatf("vec%0d.WR", i), WR, tbl[i].wd);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("rf3", rf[3], 64'h22);
    chk("rf0", rf[0], 64'h0);
    chk("rf5", rf[5], 64'hDEAD_BEEF_0000_0001);

    // reset with both buffers holding results
    drive(1, 20, 64'h5151, 1, 21, 64'h6161);
    step();
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1 chk_reset_vals("full_buf_rst");
    release_reset();
    for (int i = 0; i < 33; i++) step();
    for (int i = 0; i < 4; i++) step();
    chk("stale20", rf[20], 64'd0);
    chk("stale21", rf[21], 64'd0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 99) < 60,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
            {$urandom, $urandom},
            $urandom_range(0, 99) < 50,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
            {$urandom, $urandom});
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 32; i++)
      chk($sformatf("rf_final%0d", i), rf[i], erf[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
